// File: rtl/uart_rx_engine.sv
// uart_rx_engine: 16x oversampling UART receiver that deframes 8 data bits with optional parity,
// pushes characters with error flags, and reports break and overrun events.
module uart_rx_engine (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        rx_i,
  input  logic        enable_i,
  input  logic [15:0] divisor_i,
  input  logic        parity_en_i,
  input  logic        even_parity_i,
  input  logic        rx_full_i,
  output logic        rx_push_o,
  output logic [7:0]  rx_data_o,
  output logic        rx_perr_o,
  output logic        rx_ferr_o,
  output logic        break_o,
  output logic        rx_overrun_o,
  output logic        rx_busy_o
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;
  state_t state, state_nx;
  logic        s1, rxs, rxs_d;
  logic [15:0] baud_cnt;
  logic [3:0]  os_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        par_en, par_even, par_bit, perr;
  logic        run, tick, fall, mid, last, is_break, frame_done;
  assign run        = (divisor_i != 16'd0) && !enable_i;
  assign tick       = (divisor_i != 16'd0) && (baud_cnt >= divisor_i);
  assign fall       = rxs_d && !rxs;
  assign mid        = tick && (os_cnt == 4'd7);
  assign last       = tick && (os_cnt == 4'd15);
  assign is_break   = (shift == 8'd0) && !rxs && !(par_en && par_bit);
  assign frame_done = run && (state == STOP) && last;
  assign rx_busy_o  = state != IDLE;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) {s1, rxs, rxs_d} <= 3'b111;
    else {s1, rxs, rxs_d} <= {rx_i, s1, rxs};
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) baud_cnt <= 16'd1;
    else if (enable_i) baud_cnt <= 16'd1;
    else if (divisor_i != 16'd0) baud_cnt <= tick ? 16'd1 : baud_cnt + 16'd1;
  // os_cnt is realigned to the start edge and again to mid start bit
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) os_cnt <= 4'd0;
    else if (enable_i || (state == IDLE && fall) || (state == START && mid)) os_cnt <= 4'd0;
    else if (tick) os_cnt <= os_cnt + 4'd1;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (!run) state_nx = IDLE;
    else
      case (state)
        IDLE:     state_nx = fall ? START : IDLE;
        START:    state_nx = mid ? (rxs ? IDLE : DATA) : START;
        DATA:     state_nx = (last && bit_idx == 3'd7) ? (par_en ? PARITY : STOP) : DATA;
        PARITY:   state_nx = last ? STOP : PARITY;
        STOP:     state_nx = last ? (is_break ? BRK_WAIT : IDLE) : STOP;
        BRK_WAIT: state_nx = rxs ? IDLE : BRK_WAIT;
        default:  state_nx = IDLE;
      endcase
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      bit_idx      <= 3'd0;
      shift        <= 8'd0;
      par_en       <= 1'b0;
      par_even     <= 1'b0;
      par_bit      <= 1'b0;
      perr         <= 1'b0;
      rx_push_o    <= 1'b0;
      rx_data_o    <= 8'd0;
      rx_perr_o    <= 1'b0;
      rx_ferr_o    <= 1'b0;
      break_o      <= 1'b0;
      rx_overrun_o <= 1'b0;
    end else begin
      rx_push_o    <= 1'b0;
      break_o      <= 1'b0;
      rx_overrun_o <= 1'b0;
      if (run && state == START && mid && !rxs) begin
        bit_idx  <= 3'd0;
        par_en   <= parity_en_i;
        par_even <= even_parity_i;
        par_bit  <= 1'b0;
        perr     <= 1'b0;
      end
      if (run && state == DATA && last) begin
        shift   <= {rxs, shift[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      if (run && state == PARITY && last) begin
        par_bit <= rxs;
        perr    <= rxs ^ (par_even ? ^shift : ~^shift);
      end
      if (frame_done) begin
        if (is_break) break_o <= 1'b1;
        else if (rx_full_i) rx_overrun_o <= 1'b1;
        else begin
          rx_push_o <= 1'b1;
          rx_data_o <= shift;
          rx_perr_o <= perr;
          rx_ferr_o <= !rxs;
        end
      end
    end
endmodule

// File: tb/tb_uart_rx_engine.sv
// tb_uart_rx_engine: drives serial frames and checks every cycle against a frame-level model.
module tb_uart_rx_engine;
  logic        clk_i = 1'b0, rst_n_i = 1'b0, rx_i = 1'b1, enable_i = 1'b0;
  logic        parity_en_i = 1'b0, even_parity_i = 1'b0, rx_full_i = 1'b0;
  logic [15:0] divisor_i = 16'd4;
  logic        rx_push_o, rx_perr_o, rx_ferr_o, break_o, rx_overrun_o, rx_busy_o;
  logic [7:0]  rx_data_o;
  uart_rx_engine dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .rx_i(rx_i), .enable_i(enable_i), .divisor_i(divisor_i),
    .parity_en_i(parity_en_i), .even_parity_i(even_parity_i), .rx_full_i(rx_full_i),
    .rx_push_o(rx_push_o), .rx_data_o(rx_data_o), .rx_perr_o(rx_perr_o), .rx_ferr_o(rx_ferr_o),
    .break_o(break_o), .rx_overrun_o(rx_overrun_o), .rx_busy_o(rx_busy_o)
  );
  always #5 clk_i = ~clk_i;
  typedef struct {
    int         kind;
    logic [7:0] d;
    logic       pe;
    logic       fe;
    longint     lo;
    longint     hi;
  } ev_t;
  ev_t        exp_q[$];
  ev_t        me;
  int         checks = 0, failures = 0, mk;
  int         n_push = 0, n_brk = 0, n_ovr = 0, dv = 4;
  longint     cyc = 0, last_cyc = 0;
  logic [7:0] held_d = 8'd0, last_d = 8'd0;
  logic       held_pe = 1'b0, held_fe = 1'b0, last_pe = 1'b0, last_fe = 1'b0;
  always @(posedge clk_i) cyc <= cyc + 1;
  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
    end
  endtask
  // kind: 0 push, 1 overrun, 2 break; window covers one tick of start-edge phase uncertainty
  function automatic ev_t model(input logic [7:0] d, input logic pbit, input logic stop, input longint c);
    ev_t e;
    int  n;
    logic exp_p;
    exp_p  = (($countones(d) % 2) == 1) == even_parity_i;
    e.kind = (d == 8'd0 && !stop && !(parity_en_i && pbit)) ? 2 : rx_full_i ? 1 : 0;
    e.d    = d;
    e.pe   = parity_en_i && (pbit != exp_p);
    e.fe   = !stop;
    n      = 8 + 16 * (9 + int'(parity_en_i));
    e.lo   = c + 3 + longint'(n - 1) * dv;
    e.hi   = c + 4 + longint'(n) * dv;
    return e;
  endfunction
  always @(negedge clk_i) if (rst_n_i) begin
    mk = int'(rx_push_o) + int'(rx_overrun_o) + int'(break_o);
    if (mk > 1) chk("strobe_onehot", mk, 1);
    else if (mk == 1) begin
      if (rx_push_o) begin n_push++; last_d = rx_data_o; last_pe = rx_perr_o; last_fe = rx_ferr_o; last_cyc = cyc; end
      if (break_o) n_brk++;
      if (rx_overrun_o) n_ovr++;
      if (exp_q.size() == 0) chk("unexpected_event", mk, 0);
      else begin
        me = exp_q.pop_front();
        chk("event_kind", rx_push_o ? 0 : rx_overrun_o ? 1 : 2, me.kind);
        chk("event_in_window", longint'(cyc >= me.lo && cyc <= me.hi), 1);
        if (rx_push_o && me.kind == 0) begin
          chk("push_data", rx_data_o, me.d);
          chk("push_perr", rx_perr_o, me.pe);
          chk("push_ferr", rx_ferr_o, me.fe);
          held_d = me.d; held_pe = me.pe; held_fe = me.fe;
        end
      end
    end else if (exp_q.size() != 0 && cyc > exp_q[0].hi) begin
      checks++; failures++;
      $display("FAIL event_missing kind=%0d deadline=%0d now=%0d", exp_q[0].kind, exp_q[0].hi, cyc);
      void'(exp_q.pop_front());
    end
    if (!rx_push_o) begin
      chk("data_hold", rx_data_o, held_d);
      chk("perr_hold", rx_perr_o, held_pe);
      chk("ferr_hold", rx_ferr_o, held_fe);
    end
  end
  task automatic line(input logic v, input int n);
    rx_i = v;
    repeat (n) @(posedge clk_i);
    #1;
  endtask
  task automatic send(input logic [7:0] d, input logic pbit, input logic stop, input int gap);
    int bt;
    bt = 16 * dv;
    exp_q.push_back(model(d, pbit, stop, cyc));
    line(1'b0, bt);
    for (int i = 0; i < 8; i++) line(d[i], bt);
    if (parity_en_i) line(pbit, bt);
    line(stop, bt);
    line(1'b1, gap);
  endtask
  task automatic reprogram(input int d);
    dv = d;
    divisor_i = 16'(d);
    enable_i = 1'b1;
    @(posedge clk_i); #1;
    enable_i = 1'b0;
    line(1'b1, 10);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    int np, nb, no;
    longint c0;
    logic [7:0] d;
    logic stop;
    repeat (3) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    chk("rst_push", rx_push_o, 0);
    chk("rst_data", rx_data_o, 8'h00);
    chk("rst_perr", rx_perr_o, 0);
    chk("rst_ferr", rx_ferr_o, 0);
    chk("rst_break", break_o, 0);
    chk("rst_overrun", rx_overrun_o, 0);
    chk("rst_busy", rx_busy_o, 0);
    np = n_push; c0 = cyc;
    send(8'hA5, 1'b0, 1'b1, 20);
    chk("a5_count", n_push, np + 1);
    chk("a5_data", last_d, 8'hA5);
    chk("a5_perr", last_pe, 0);
    chk("a5_ferr", last_fe, 0);
    chk("a5_latency_ok", longint'(last_cyc - c0 >= 606 && last_cyc - c0 <= 613), 1);
    parity_en_i = 1'b1; even_parity_i = 1'b1;
    send(8'h03, 1'b1, 1'b1, 20);
    chk("even_03_data", last_d, 8'h03);
    chk("even_03_perr", last_pe, 1);
    even_parity_i = 1'b0;
    send(8'h03, 1'b1, 1'b1, 20);
    chk("odd_03_perr", last_pe, 0);
    parity_en_i = 1'b0;
    send(8'h55, 1'b0, 1'b0, 20);
    chk("ferr_55_data", last_d, 8'h55);
    chk("ferr_55_ferr", last_fe, 1);
    chk("ferr_55_perr", last_pe, 0);
    nb = n_brk; np = n_push;
    exp_q.push_back(model(8'h00, 1'b0, 1'b0, cyc));
    line(1'b0, 12 * 16 * dv);
    chk("brk_busy_low", rx_busy_o, 1);
    line(1'b1, 40);
    chk("brk_busy_released", rx_busy_o, 0);
    chk("brk_count", n_brk, nb + 1);
    chk("brk_no_push", n_push, np);
    send(8'h3C, 1'b0, 1'b1, 20);
    chk("post_brk_data", last_d, 8'h3C);
    rx_full_i = 1'b1; no = n_ovr; np = n_push;
    send(8'h7E, 1'b0, 1'b1, 20);
    chk("ovr_count", n_ovr, no + 1);
    chk("ovr_no_push", n_push, np);
    rx_full_i = 1'b0;
    send(8'h7E, 1'b0, 1'b1, 20);
    chk("after_ovr_push", n_push, np + 1);
    chk("after_ovr_data", last_d, 8'h7E);
    np = n_push;
    line(1'b0, 20);
    line(1'b1, 200);
    chk("glitch_idle", rx_busy_o, 0);
    chk("glitch_no_push", n_push, np);
    line(1'b0, 64);
    line(1'b1, 64);
    line(1'b0, 64);
    enable_i = 1'b1; rx_i = 1'b1;
    @(posedge clk_i); #1;
    enable_i = 1'b0;
    chk("enable_idle", rx_busy_o, 0);
    line(1'b1, 100);
    chk("enable_no_push", n_push, np);
    send(8'h5A, 1'b0, 1'b1, 20);
    chk("post_enable_data", last_d, 8'h5A);
    for (int it = 0; it < 30; it++) begin
      if (it % 6 == 0) reprogram(int'($urandom_range(1, 4)));
      parity_en_i   = 1'($urandom);
      even_parity_i = 1'($urandom);
      rx_full_i     = ($urandom % 4) == 0;
      d    = ($urandom % 8 == 0) ? 8'h00 : 8'($urandom);
      stop = ($urandom % 4) != 0;
      send(d, 1'($urandom), stop, stop ? int'($urandom_range(0, 10)) : int'($urandom_range(4, 20)));
    end
    rx_full_i = 1'b0;
    line(1'b1, 300);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_rx_engine.md
# uart_rx_engine

Serial receive engine of the APB UART. It samples the asynchronous `rx_i` line with 16x oversampling at the rate set by the divisor register and deframes start, 8 data bits, optional parity and stop. Each completed character is pushed into the RX FIFO with its parity and frame error flags, and break and overrun events are reported to the register bank. The engine sits between the UART pin and the RX FIFO. Its configuration comes from the register bank outputs: divisor value, enable pulse, parity enable and even parity.

## Interface
No parameters; all widths fixed.
- `clk_i`  in  1  system clock; all logic on rising edge
- `rst_n_i`  in  1  asynchronous reset, active-low
- `rx_i`  in  1  serial input, asynchronous to `clk_i`, idle high
- `enable_i`  in  1  one-cycle pulse issued when the divisor is written; restarts the engine
- `divisor_i`  in  16  oversample tick period in clocks; 0 = receiver disabled
- `parity_en_i`  in  1  a parity bit follows the data bits
- `even_parity_i`  in  1  1 = even parity, 0 = odd parity
- `rx_full_i`  in  1  RX FIFO full
- `rx_push_o`  out  1  one-cycle FIFO write strobe
- `rx_data_o`  out  8  received character, valid with `rx_push_o`
- `rx_perr_o`  out  1  parity error for the character, valid with `rx_push_o`
- `rx_ferr_o`  out  1  frame error (stop bit = 0), valid with `rx_push_o`
- `break_o`  out  1  one-cycle pulse per break condition
- `rx_overrun_o`  out  1  one-cycle pulse when a character is lost because the FIFO is full
- `rx_busy_o`  out  1  FSM not in IDLE

## Operation
- **Input synchronizer:** 2-flop synchronizer on `rx_i`, both flops reset to 1. All logic uses the synchronized value `rxs`.
- **Baud tick generator:**
  - Counter runs 1..`divisor_i`; `tick` is asserted for one clock when the count equals `divisor_i`, then the count returns to 1.
  - Tick period = `divisor_i` clocks; bit time = 16 × `divisor_i` clocks.
  - `divisor_i` = 0: counter held, no ticks, FSM forced to IDLE.
- **Oversample counter `os_cnt`:** 4 bits, advances on `tick`, wraps 15→0.
- **FSM states:** IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
  - **IDLE:** a falling edge on `rxs` (previous 1, current 0) clears `os_cnt` and moves to START.
  - **START:** on the tick where `os_cnt` = 7 (mid start bit):
    - `rxs` = 0 → clear `os_cnt`, clear bit index, go to DATA.
    - `rxs` = 1 → glitch; return to IDLE.
  - **DATA:** on each tick where `os_cnt` = 15, sample `rxs` into the shift register, LSB first. After the 8th bit, go to PARITY if `parity_en_i`, else STOP.
  - **PARITY:** on the tick where `os_cnt` = 15, sample the parity bit.
    - Expected bit = XOR(data) when `even_parity_i` = 1, ~XOR(data) when 0.
    - `perr` = sampled ≠ expected. `perr` is 0 when parity is disabled.
  - **STOP:** on the tick where `os_cnt` = 15, sample the stop bit.
    - Break: data = 0, stop = 0, and the parity bit (if enabled) = 0. Pulse `break_o`, do not push, go to BRK_WAIT.
    - Otherwise: `ferr` = ~stop. If `rx_full_i` = 0, pulse `rx_push_o` with data, `perr` and `ferr`; if `rx_full_i` = 1, pulse `rx_overrun_o` and drop the character. Go to IDLE.
  - **BRK_WAIT:** stay until `rxs` = 1, then go to IDLE. No further break pulse is issued for the same low period.
- **Configuration sampling:** `parity_en_i` and `even_parity_i` are sampled at the START→DATA transition and held for the frame.
- **Enable pulse:** `enable_i` = 1 in any state aborts the frame (no push, no flag pulses), clears the baud and oversample counters, and forces IDLE. The next falling edge is accepted no earlier than the cycle after the pulse.

## Timing
- **Reset values:** all outputs 0 (`rx_data_o` = 0x00); FSM in IDLE; synchronizer flops at 1.
- **Registered outputs:** `rx_push_o`, `break_o` and `rx_overrun_o` are registered. Each is high for exactly one clock, in the cycle after the stop-sample tick.
  - `rx_data_o`, `rx_perr_o` and `rx_ferr_o` are stable from that cycle until the next push.
- **Latency:** from the `rx_i` falling edge to `rx_push_o`, about (9.5 + parity_en) bit times + 3 clocks, ± 1 tick of phase uncertainty.
- **`rx_busy_o`:** rises the cycle after IDLE is exited and falls the cycle IDLE is re-entered.
- **Stop-bit re-arm:** IDLE is re-entered mid stop bit, so a start edge immediately after the stop bit is not missed.
- **Reset:** asserting `rst_n_i` mid-frame clears everything immediately; no pulse is emitted.
- **Simultaneous events:** `enable_i` in the same cycle as a stop-sample tick wins; no push.

## Test plan
- `divisor_i` = 4, no parity; send 0xA5 with stop = 1 → one `rx_push_o`, `rx_data_o` = 0xA5, `rx_perr_o` = 0, `rx_ferr_o` = 0, about 611 clocks after the start edge.
- Even parity; send 0x03 with parity bit = 1 → push with data 0x03, `rx_perr_o` = 1. Odd parity, same frame → `rx_perr_o` = 0.
- Send 0x55 with stop = 0 → push with `rx_ferr_o` = 1, `rx_perr_o` = 0.
- Hold `rx_i` low for 12 bit times, then release → exactly one `break_o` pulse, no push, `rx_busy_o` = 1 until the line returns high, after which the next frame 0x3C is received correctly.
- `rx_full_i` = 1 during a 0x7E frame → no push, one `rx_overrun_o` pulse. With `rx_full_i` = 0 on the next frame → normal push.
- Low glitch of 20 clocks (under half a bit) → no push, return to IDLE. `enable_i` pulse mid-data → no push, engine idle, next frame received correctly.
